// File: rtl/udt_pkg.sv
// Shared UDT definitions: control-packet constants, handshake FSM states,
// the latched handshake field bundle and the beat-word formatter.
package udt_pkg;

    localparam logic [14:0] CTRL_HANDSHAKE = 15'h0;
    localparam int          HS_BEATS       = 8;
    localparam logic [31:0] REQ_REGULAR    = 32'h1;
    localparam logic [31:0] REQ_RESPONSE   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT
    } hs_state_t;

    typedef logic [$clog2(HS_BEATS)-1:0] beat_idx_t;

    localparam beat_idx_t LAST_BEAT = beat_idx_t'(HS_BEATS - 1);

    typedef struct packed {
        logic [31:0]  req_type;
        logic [31:0]  isn;
        logic [31:0]  mss;
        logic [31:0]  flight_size;
        logic [31:0]  sock_id;
        logic [31:0]  cookie;
        logic [31:0]  dst_sock_id;
        logic [127:0] peer_ip;
    } hs_fields_t;

    // Upper word of each beat goes first on the wire.
    function automatic logic [63:0] hs_beat_word(
        input beat_idx_t   beat,
        input hs_fields_t  f,
        input logic [31:0] ts,
        input logic [31:0] version,
        input logic [31:0] sock_type
    );
        logic [63:0] w;
        case (beat)
            3'd0:    w = {1'b1, CTRL_HANDSHAKE, 16'h0, 32'h0};
            3'd1:    w = {ts, f.dst_sock_id};
            3'd2:    w = {version, sock_type};
            3'd3:    w = {f.isn, f.mss};
            3'd4:    w = {f.flight_size, f.req_type};
            3'd5:    w = {f.sock_id, f.cookie};
            3'd6:    w = f.peer_ip[127:64];
            default: w = f.peer_ip[63:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/udt_hs_retx_timer.sv
// Loadable 32-bit down-counter for handshake retransmission; expire fires
// while running at zero, cancel forwards a stop request while running.
module udt_hs_retx_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        run,
    input  logic        stop,
    output logic        expire,
    output logic        cancel
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (run && (cnt_q != 32'd0)) begin
            cnt_d = cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = run && (cnt_q == 32'd0);
    assign cancel = run && stop;

endmodule

// File: rtl/udt_handshake_tx.sv
// UDT handshake packet builder: latches one command and emits an 8-beat
// 64-bit stream packet. Define UDT_HS_RETX_EN to enable timed resends.
module udt_handshake_tx
    import udt_pkg::*;
#(
    parameter logic [31:0] VERSION     = 32'd4,
    parameter logic [31:0] SOCK_TYPE   = 32'd1,
    parameter logic [31:0] RETX_CYCLES = 32'd25_000_000
) (
    input  logic         core_clk,
    input  logic         core_rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [31:0]  cmd_req_type,
    input  logic [31:0]  cmd_isn,
    input  logic [31:0]  cmd_mss,
    input  logic [31:0]  cmd_flight_size,
    input  logic [31:0]  cmd_sock_id,
    input  logic [31:0]  cmd_cookie,
    input  logic [31:0]  cmd_dst_sock_id,
    input  logic [127:0] cmd_peer_ip,
    input  logic [31:0]  time_us,
    input  logic         retx_stop,
    output logic [63:0]  hs_tdata,
    output logic [7:0]   hs_tkeep,
    output logic         hs_tvalid,
    input  logic         hs_tready,
    output logic         hs_tlast,
    output logic         busy,
    output logic [15:0]  pkt_count
);

    hs_state_t   state_q, state_d;
    beat_idx_t   beat_q, beat_d;
    hs_fields_t  fields_q, fields_d;
    logic [31:0] ts_q, ts_d;
    logic [15:0] pkt_count_q, pkt_count_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic        hs_tvalid_q, hs_tvalid_d;
    logic        hs_tlast_q, hs_tlast_d;
    logic [7:0]  hs_tkeep_q, hs_tkeep_d;
    logic [63:0] hs_tdata_q, hs_tdata_d;
    logic        accept;

`ifdef UDT_HS_RETX_EN
    logic stop_pend_q, stop_pend_d;
    logic load_timer;
    logic retx_expire;
    logic retx_cancel;

    udt_hs_retx_timer u_retx_timer (
        .clk      (core_clk),
        .rst_n    (core_rst_n),
        .load     (load_timer),
        .load_val (RETX_CYCLES - 32'd1),
        .run      (state_q == ST_WAIT),
        .stop     (retx_stop),
        .expire   (retx_expire),
        .cancel   (retx_cancel)
    );
`else
    logic unused_retx;
    assign unused_retx = retx_stop ^ RETX_CYCLES[0];
`endif

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        fields_d    = fields_q;
        ts_d        = ts_q;
        pkt_count_d = pkt_count_q;
        accept      = 1'b0;
`ifdef UDT_HS_RETX_EN
        load_timer  = 1'b0;
        // A stop seen at any point of a packet suppresses arming at its end.
        stop_pend_d = (state_q == ST_SEND) ? (stop_pend_q | retx_stop) : 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                accept = cmd_valid;
            end
            ST_SEND: begin
                if (hs_tvalid_q && hs_tready) begin
                    if (beat_q == LAST_BEAT) begin
                        pkt_count_d = pkt_count_q + 16'd1;
                        state_d     = ST_IDLE;
`ifdef UDT_HS_RETX_EN
                        if ((fields_q.req_type == REQ_REGULAR) && !stop_pend_d) begin
                            state_d    = ST_WAIT;
                            load_timer = 1'b1;
                        end
`endif
                    end else begin
                        beat_d = beat_q + beat_idx_t'(1);
                    end
                end
            end
`ifdef UDT_HS_RETX_EN
            ST_WAIT: begin
                // A new command outranks both the stop pulse and the resend.
                if (cmd_valid) begin
                    accept = 1'b1;
                end else if (retx_cancel) begin
                    state_d = ST_IDLE;
                end else if (retx_expire) begin
                    state_d = ST_SEND;
                    beat_d  = '0;
                    ts_d    = time_us;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_d  = ST_SEND;
            beat_d   = '0;
            ts_d     = time_us;
            fields_d = '{req_type:    cmd_req_type,
                         isn:         cmd_isn,
                         mss:         cmd_mss,
                         flight_size: cmd_flight_size,
                         sock_id:     cmd_sock_id,
                         cookie:      cmd_cookie,
                         dst_sock_id: cmd_dst_sock_id,
                         peer_ip:     cmd_peer_ip};
        end

        // Outputs are registered from next-state so beat 0 follows acceptance by one cycle.
        hs_tvalid_d = (state_d == ST_SEND);
        hs_tlast_d  = hs_tvalid_d && (beat_d == LAST_BEAT);
        hs_tkeep_d  = hs_tvalid_d ? 8'hFF : 8'h00;
        hs_tdata_d  = hs_tvalid_d ? hs_beat_word(beat_d, fields_d, ts_d, VERSION, SOCK_TYPE)
                                  : 64'h0;
        cmd_ready_d = (state_d != ST_SEND);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            pkt_count_q <= 16'd0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            hs_tvalid_q <= 1'b0;
            hs_tlast_q  <= 1'b0;
            hs_tkeep_q  <= 8'h00;
            hs_tdata_q  <= 64'h0;
`ifdef UDT_HS_RETX_EN
            stop_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            pkt_count_q <= pkt_count_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            hs_tvalid_q <= hs_tvalid_d;
            hs_tlast_q  <= hs_tlast_d;
            hs_tkeep_q  <= hs_tkeep_d;
            hs_tdata_q  <= hs_tdata_d;
`ifdef UDT_HS_RETX_EN
            stop_pend_q <= stop_pend_d;
`endif
        end
    end

    // Latched command fields carry no reset; they are only read in SEND.
    always_ff @(posedge core_clk) begin
        fields_q <= fields_d;
        ts_q     <= ts_d;
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign pkt_count = pkt_count_q;
    assign hs_tvalid = hs_tvalid_q;
    assign hs_tlast  = hs_tlast_q;
    assign hs_tkeep  = hs_tkeep_q;
    assign hs_tdata  = hs_tdata_q;

endmodule
